// File: rtl/lab_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
package lab_pkg;

   // Index of XZR; it always reads as zero, so a write to it is never a dependency.
   localparam int XZR = 31;

   // Sequencing states: normal flow, waiting on data memory, dead after timeout.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } hz_state_t;

   // Condition flags in {N,Z,V,C} order.
   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and sequencing outputs for the hazard controller.
// master = the pipeline datapath side, slave = the controller.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   import lab_pkg::*;

   // ID / EX operand information
   logic [REG_AW-1:0] id_rn;
   logic [REG_AW-1:0] id_rm;
   logic              id_uses_rn;
   logic              id_uses_rm;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_mem_read;

   // EX ALU flags and branch kind
   logic              ex_set_flag;
   logic              alu_n;
   logic              alu_z;
   logic              alu_v;
   logic              alu_c;
   logic              ex_uncond_br;
   logic              ex_check_lt;
   logic              ex_cbz;
   logic              ex_cbz_zero;

   // MEM-stage handshake
   logic              mem_access;
   logic              mem_ready;

   // Controls back to the datapath
   logic              pc_en;
   logic              ifid_en;
   logic              idex_en;
   logic              exmem_en;
   logic              memwb_en;
   logic              ifid_flush;
   logic              idex_flush;
   logic              br_taken;
   flags_t            flags_q;
   logic              halted;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_mem_read,
      output ex_set_flag, alu_n, alu_z, alu_v, alu_c,
      output ex_uncond_br, ex_check_lt, ex_cbz, ex_cbz_zero,
      output mem_access, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      input  ifid_flush, idex_flush, br_taken, flags_q, halted, stall_cnt
   );

   modport slave (
      input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_mem_read,
      input  ex_set_flag, alu_n, alu_z, alu_v, alu_c,
      input  ex_uncond_br, ex_check_lt, ex_cbz, ex_cbz_zero,
      input  mem_access, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      output ifid_flush, idex_flush, br_taken, flags_q, halted, stall_cnt
   );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a load in EX whose destination is read by
// the instruction in ID forces a one-cycle bubble.
module load_use_detect #(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 31
) (
   input  logic [REG_AW-1:0] id_rn,
   input  logic [REG_AW-1:0] id_rm,
   input  logic              id_uses_rn,
   input  logic              id_uses_rm,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   output logic              hazard
);
   localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

   logic [REG_AW-1:0] src_idx [2];
   logic [1:0]        src_use;
   logic [1:0]        src_hit;

   assign src_idx[0] = id_rn;
   assign src_idx[1] = id_rm;
   assign src_use    = {id_uses_rm, id_uses_rn};

   // One comparator per source operand of the ID instruction.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = src_use[gi] & (src_idx[gi] == ex_rd);
      end
   endgenerate

   // XZR as a destination is discarded, so it never creates a dependency.
   assign hazard = ex_mem_read & (ex_rd != ZERO_IDX) & (|src_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage LEGv8 pipeline: flag register,
// EX branch resolution, load-use stall, memory wait freeze and timeout halt.
module pipeline_hazard_ctrl
   import lab_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int ZERO_REG    = XZR,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   hz_state_t         state_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic              halted_reg;
   flags_t            flags_reg;
   logic [CNT_W-1:0]  stall_cnt_reg;

   logic load_use;
   logic frozen;
   logic br_cond;
   logic br_take;
   logic stall;

   load_use_detect #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
   ) u_load_use (
      .id_rn       (hz.id_rn),
      .id_rm       (hz.id_rm),
      .id_uses_rn  (hz.id_uses_rn),
      .id_uses_rm  (hz.id_uses_rm),
      .ex_rd       (hz.ex_rd),
      .ex_mem_read (hz.ex_mem_read),
      .hazard      (load_use)
   );

   // Freeze, branch decision and stall qualification; a taken branch beats a load-use bubble.
   always_comb begin
      frozen  = 1'b0;
      br_cond = 1'b0;
      br_take = 1'b0;
      stall   = 1'b0;
      frozen  = (state_reg != RUN) | (hz.mem_access & ~hz.mem_ready);
      br_cond = hz.ex_uncond_br
              | (hz.ex_check_lt & (flags_reg.n ^ flags_reg.v))
              | (hz.ex_cbz & hz.ex_cbz_zero);
      br_take = br_cond & ~frozen;
      stall   = load_use & ~frozen & ~br_take;
   end

   assign hz.pc_en      = ~frozen & ~stall;
   assign hz.ifid_en    = ~frozen & ~stall;
   assign hz.idex_en    = ~frozen;
   assign hz.exmem_en   = ~frozen;
   assign hz.memwb_en   = ~frozen;
   assign hz.br_taken   = br_take;
   assign hz.ifid_flush = br_take;
   assign hz.idex_flush = br_take | stall;
   assign hz.flags_q    = flags_reg;
   assign hz.halted     = halted_reg;
   assign hz.stall_cnt  = stall_cnt_reg;

   // Memory-wait FSM with timeout watchdog; HALT is only left through reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= RUN;
         wait_cnt_reg <= '0;
         halted_reg   <= 1'b0;
      end else begin
         case (state_reg)
            RUN: begin
               if (hz.mem_access && !hz.mem_ready) begin
                  wait_cnt_reg <= WAIT_ONE;
                  if (MEM_TIMEOUT <= 1) begin
                     state_reg  <= HALT;
                     halted_reg <= 1'b1;
                  end else begin
                     state_reg <= MEM_WAIT;
                  end
               end
            end
            MEM_WAIT: begin
               if (hz.mem_ready) begin
                  state_reg    <= RUN;
                  wait_cnt_reg <= '0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
                  if (wait_cnt_reg == WAIT_LAST) begin
                     state_reg  <= HALT;
                     halted_reg <= 1'b1;
                  end
               end
            end
            HALT: begin
               halted_reg <= 1'b1;
            end
            default: begin
               state_reg <= RUN;
            end
         endcase
      end
   end

   // NZVC capture from flag-setting ops; a frozen pipeline does not commit flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_reg <= '0;
      end else if (hz.ex_set_flag && !frozen) begin
         flags_reg <= '{n: hz.alu_n, z: hz.alu_z, v: hz.alu_v, c: hz.alu_c};
      end
   end

   // Saturating count of cycles in which the PC did not advance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else if (!hz.pc_en && !(&stall_cnt_reg)) begin
         stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   logic [15:0] exp_stall;

   pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();

   pipeline_hazard_ctrl #(
      .REG_AW      (5),
      .ZERO_REG    (31),
      .MEM_TIMEOUT (15),
      .CNT_W       (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (bus)
   );

   // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, br_taken}
   wire [7:0] ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                     bus.ifid_flush, bus.idex_flush, bus.br_taken};

   localparam logic [7:0] CTL_RUN    = 8'b11111_000;
   localparam logic [7:0] CTL_STALL  = 8'b00111_010;
   localparam logic [7:0] CTL_BRANCH = 8'b11111_111;
   localparam logic [7:0] CTL_FROZEN = 8'b00000_000;

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.id_rn = 5'd0;  bus.id_rm = 5'd0;
      bus.id_uses_rn = 1'b0; bus.id_uses_rm = 1'b0;
      bus.ex_rd = 5'd0;  bus.ex_mem_read = 1'b0;
      bus.ex_set_flag = 1'b0;
      bus.alu_n = 1'b0; bus.alu_z = 1'b0; bus.alu_v = 1'b0; bus.alu_c = 1'b0;
      bus.ex_uncond_br = 1'b0; bus.ex_check_lt = 1'b0;
      bus.ex_cbz = 1'b0; bus.ex_cbz_zero = 1'b0;
      bus.mem_access = 1'b0; bus.mem_ready = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (bus.flags_q !== 4'b0000) begin
         bad++; $display("FAIL reset_flags got=%b want=0000", bus.flags_q);
      end
      total++;
      if (bus.halted !== 1'b0) begin
         bad++; $display("FAIL reset_halted got=%b want=0", bus.halted);
      end
      total++;
      if (bus.stall_cnt !== 16'd0) begin
         bad++; $display("FAIL reset_stall_cnt got=%0d want=0", bus.stall_cnt);
      end
      total++;
      if (ctl !== CTL_RUN) begin
         bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, CTL_RUN);
      end
      $display("reset: flags=%b halted=%b stall_cnt=%0d ctl=%b", bus.flags_q, bus.halted, bus.stall_cnt, ctl);
   endtask

   task automatic test_load_use;
      // LDUR X1 in EX, ADDS X3,X1,X2 in ID
      tick();
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd1;
      bus.id_rn = 5'd1; bus.id_uses_rn = 1'b1;
      bus.id_rm = 5'd2; bus.id_uses_rm = 1'b1;
      #1;
      total++;
      if (ctl !== CTL_STALL) begin
         bad++; $display("FAIL lu_rn_ctl got=%b want=%b", ctl, CTL_STALL);
      end
      $display("load_use rn: ctl=%b", ctl);
      tick();
      exp_stall = exp_stall + 16'd1;
      idle();
      #1;
      total++;
      if (ctl !== CTL_RUN) begin
         bad++; $display("FAIL lu_after_ctl got=%b want=%b", ctl, CTL_RUN);
      end
      total++;
      if (bus.stall_cnt !== exp_stall) begin
         bad++; $display("FAIL lu_stall_cnt got=%0d want=%0d", bus.stall_cnt, exp_stall);
      end
      $display("load_use next: ctl=%b stall_cnt=%0d", ctl, bus.stall_cnt);
      // dependency through rm only
      tick();
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7;
      bus.id_rn = 5'd4; bus.id_uses_rn = 1'b1;
      bus.id_rm = 5'd7; bus.id_uses_rm = 1'b1;
      #1;
      total++;
      if (ctl !== CTL_STALL) begin
         bad++; $display("FAIL lu_rm_ctl got=%b want=%b", ctl, CTL_STALL);
      end
      $display("load_use rm: ctl=%b", ctl);
      tick();
      exp_stall = exp_stall + 16'd1;
      // rm matches but is not read (immediate form) -> no stall
      bus.id_uses_rm = 1'b0;
      #1;
      total++;
      if (ctl !== CTL_RUN) begin
         bad++; $display("FAIL lu_unused_ctl got=%b want=%b", ctl, CTL_RUN);
      end
      $display("load_use unused rm: ctl=%b", ctl);
      tick();
      idle();
   endtask

   task automatic test_xzr;
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd31;
      bus.id_rn = 5'd31; bus.id_uses_rn = 1'b1;
      bus.id_rm = 5'd31; bus.id_uses_rm = 1'b1;
      #1;
      total++;
      if (ctl !== CTL_RUN) begin
         bad++; $display("FAIL xzr_ctl got=%b want=%b", ctl, CTL_RUN);
      end
      tick();
      idle();
      #1;
      total++;
      if (bus.stall_cnt !== exp_stall) begin
         bad++; $display("FAIL xzr_stall_cnt got=%0d want=%0d", bus.stall_cnt, exp_stall);
      end
      $display("xzr: ctl=%b stall_cnt=%0d", ctl, bus.stall_cnt);
   endtask

   task automatic test_blt;
      // SUBS 3-5 = -2: N=1 Z=0 V=0 C=0
      tick();
      bus.ex_set_flag = 1'b1;
      bus.alu_n = 1'b1; bus.alu_z = 1'b0; bus.alu_v = 1'b0; bus.alu_c = 1'b0;
      tick();
      idle();
      bus.ex_check_lt = 1'b1;
      #1;
      total++;
      if (bus.flags_q !== 4'b1000) begin
         bad++; $display("FAIL blt_flags_neg got=%b want=1000", bus.flags_q);
      end
      total++;
      if (ctl !== CTL_BRANCH) begin
         bad++; $display("FAIL blt_taken_ctl got=%b want=%b", ctl, CTL_BRANCH);
      end
      $display("b.lt after 3-5: flags=%b ctl=%b", bus.flags_q, ctl);
      // SUBS 5-3 = 2: N=0 Z=0 V=0 C=1
      tick();
      idle();
      bus.ex_set_flag = 1'b1;
      bus.alu_c = 1'b1;
      tick();
      idle();
      bus.ex_check_lt = 1'b1;
      #1;
      total++;
      if (bus.flags_q !== 4'b0001) begin
         bad++; $display("FAIL blt_flags_pos got=%b want=0001", bus.flags_q);
      end
      total++;
      if (ctl !== CTL_RUN) begin
         bad++; $display("FAIL blt_not_taken_ctl got=%b want=%b", ctl, CTL_RUN);
      end
      $display("b.lt after 5-3: flags=%b ctl=%b", bus.flags_q, ctl);
      tick();
      idle();
   endtask

   task automatic test_branch_vs_hazard;
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd2;
      bus.id_rn = 5'd2; bus.id_uses_rn = 1'b1;
      bus.ex_cbz = 1'b1; bus.ex_cbz_zero = 1'b1;
      #1;
      total++;
      if (ctl !== CTL_BRANCH) begin
         bad++; $display("FAIL cbz_hazard_ctl got=%b want=%b", ctl, CTL_BRANCH);
      end
      $display("cbz zero + load_use: ctl=%b", ctl);
      tick();
      bus.ex_cbz_zero = 1'b0;
      #1;
      total++;
      if (ctl !== CTL_STALL) begin
         bad++; $display("FAIL cbz_nonzero_ctl got=%b want=%b", ctl, CTL_STALL);
      end
      $display("cbz nonzero + load_use: ctl=%b", ctl);
      tick();
      exp_stall = exp_stall + 16'd1;
      idle();
   endtask

   task automatic test_mem_wait;
      // frozen while a branch and a flag write sit in EX
      bus.mem_access = 1'b1; bus.mem_ready = 1'b0;
      bus.ex_uncond_br = 1'b1;
      bus.ex_set_flag = 1'b1; bus.alu_z = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (ctl !== CTL_FROZEN) begin
            bad++; $display("FAIL memwait_ctl cycle=%0d got=%b want=%b", i, ctl, CTL_FROZEN);
         end
         $display("mem wait cycle %0d: ctl=%b", i, ctl);
         tick();
         exp_stall = exp_stall + 16'd1;
      end
      total++;
      if (bus.flags_q !== 4'b0001) begin
         bad++; $display("FAIL memwait_flags got=%b want=0001", bus.flags_q);
      end
      // ready arrives while still in the wait state: the stages hold one more edge
      bus.mem_ready = 1'b1;
      #1;
      total++;
      if (ctl !== CTL_FROZEN) begin
         bad++; $display("FAIL memwait_ready_ctl got=%b want=%b", ctl, CTL_FROZEN);
      end
      $display("mem wait ready cycle: ctl=%b", ctl);
      tick();
      exp_stall = exp_stall + 16'd1;
      bus.mem_access = 1'b0;
      #1;
      total++;
      if (ctl !== CTL_BRANCH) begin
         bad++; $display("FAIL memwait_resume_ctl got=%b want=%b", ctl, CTL_BRANCH);
      end
      total++;
      if (bus.stall_cnt !== exp_stall) begin
         bad++; $display("FAIL memwait_stall_cnt got=%0d want=%0d", bus.stall_cnt, exp_stall);
      end
      $display("mem wait resume: ctl=%b stall_cnt=%0d", ctl, bus.stall_cnt);
      tick();
      idle();
      #1;
      total++;
      if (bus.flags_q !== 4'b0100) begin
         bad++; $display("FAIL memwait_flags_commit got=%b want=0100", bus.flags_q);
      end
      $display("flags after resume: %b", bus.flags_q);
   endtask

   task automatic test_timeout_reset;
      tick();
      bus.mem_access = 1'b1; bus.mem_ready = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      total++;
      if (bus.halted !== 1'b0) begin
         bad++; $display("FAIL timeout_early got=%b want=0", bus.halted);
      end
      $display("after 14 low cycles: halted=%b", bus.halted);
      tick();
      total++;
      if (bus.halted !== 1'b1) begin
         bad++; $display("FAIL timeout_halt got=%b want=1", bus.halted);
      end
      $display("after 15 low cycles: halted=%b", bus.halted);
      idle();
      tick();
      tick();
      tick();
      total++;
      if ({bus.halted, ctl} !== {1'b1, CTL_FROZEN}) begin
         bad++; $display("FAIL halt_sticky got=%b/%b want=1/%b", bus.halted, ctl, CTL_FROZEN);
      end
      $display("halt held: halted=%b ctl=%b", bus.halted, ctl);
      reset = 1'b1;
      #1;
      total++;
      if ({bus.halted, bus.flags_q, bus.stall_cnt} !== 21'd0) begin
         bad++; $display("FAIL halt_reset got halted=%b flags=%b stall=%0d want=0/0000/0",
                         bus.halted, bus.flags_q, bus.stall_cnt);
      end
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (ctl !== CTL_RUN) begin
         bad++; $display("FAIL reset_run_ctl got=%b want=%b", ctl, CTL_RUN);
      end
      $display("after reset: halted=%b flags=%b ctl=%b", bus.halted, bus.flags_q, ctl);
   endtask

   initial begin
      clk = 1'b0;
      reset = 1'b1;
      total = 0;
      bad = 0;
      exp_stall = 16'd0;
      idle();
      test_reset();
      test_load_use();
      test_xzr();
      test_blt();
      test_branch_vs_hazard();
      test_mem_wait();
      test_timeout_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
